// File: rtl/multi_cycle_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset controller.
// Opcodes, FSM state codes, datapath select encodings, control bundle.
package multi_cycle_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [3:0] {
        S_IF      = 4'd0,
        S_ID      = 4'd1,
        S_EX_R    = 4'd2,
        S_EX_I    = 4'd3,
        S_EX_ADDR = 4'd4,
        S_MEM_RD  = 4'd5,
        S_MEM_WR  = 4'd6,
        S_WB_R    = 4'd7,
        S_WB_I    = 4'd8,
        S_WB_MEM  = 4'd9,
        S_BR      = 4'd10,
        S_JMP     = 4'd11
    } state_t;

    typedef enum logic [2:0] {
        C_R,
        C_IALU,
        C_LW,
        C_SW,
        C_BEQ,
        C_BNE,
        C_J,
        C_ILL
    } iclass_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_IMM   = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Control/handshake bundle between the multi-cycle FSM and its datapath.
// master = controller side, slave = datapath/memory side.
interface multi_cycle_ctrl_if;

    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, pc_src, ir_write, iord,
        output mem_read, mem_write, reg_write,
        output reg_dst, mem_to_reg, alu_src_a,
        output alu_src_b, alu_op
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, pc_src, ir_write, iord,
        input  mem_read, mem_write, reg_write,
        input  reg_dst, mem_to_reg, alu_src_a,
        input  alu_src_b, alu_op
    );

endinterface

// File: rtl/mc_opcode_decode.sv
// Opcode to instruction-class decoder for the multi-cycle controller.
module mc_opcode_decode
    import multi_cycle_pkg::*;
(
    input  logic [5:0] opcode_i,
    output iclass_t    class_o
);

    always_comb begin
        class_o = C_ILL;
        unique case (1'b1)
            (opcode_i == OP_RTYPE): class_o = C_R;
            (opcode_i == OP_ADDI):  class_o = C_IALU;
            (opcode_i == OP_SLTI):  class_o = C_IALU;
            (opcode_i == OP_LW):    class_o = C_LW;
            (opcode_i == OP_SW):    class_o = C_SW;
            (opcode_i == OP_BEQ):   class_o = C_BEQ;
            (opcode_i == OP_BNE):   class_o = C_BNE;
            (opcode_i == OP_J):     class_o = C_J;
            default:                class_o = C_ILL;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Moore control FSM for a shared-ALU, shared-memory multi-cycle datapath,
// with memory-ready stalls and a retired-instruction counter.
module multi_cycle_ctrl
    import multi_cycle_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [5:0]       opcode_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             pc_write_o,
    output logic [1:0]       pc_src_o,
    output logic             ir_write_o,
    output logic             iord_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             reg_write_o,
    output logic             reg_dst_o,
    output logic             mem_to_reg_o,
    output logic             alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [1:0]       alu_op_o,
    output logic             illegal_o,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] retired_o
);

    state_t           state;
    state_t           state_nxt;
    iclass_t          cls;
    ctrl_t            ctl;
    logic             retire;
    logic [CNT_W-1:0] retired;

    mc_opcode_decode u_dec (
        .opcode_i (opcode_i),
        .class_o  (cls)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= S_IF;
        end else begin
            state <= state_nxt;
        end
    end

    // Only completed instructions count; the illegal path leaves from ID.
    assign retire = (state != S_IF) && (state != S_ID) &&
                    (state_nxt == S_IF);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            retired <= '0;
        end else if (retire) begin
            retired <= retired + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        ctl       = CTRL_IDLE;
        case (state)
            S_IF: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = SRCB_FOUR;
                ctl.alu_op    = ALU_ADD;
                // Ready is masked while reset holds the FSM in fetch.
                if (mem_ready_i && rst_i) begin
                    ctl.ir_write = 1'b1;
                    ctl.pc_write = 1'b1;
                    ctl.pc_src   = PC_ALU;
                    state_nxt    = S_ID;
                end
            end
            S_ID: begin
                ctl.alu_src_b = SRCB_IMM_SH2;
                ctl.alu_op    = ALU_ADD;
                unique case (cls)
                    C_R:    state_nxt = S_EX_R;
                    C_IALU: state_nxt = S_EX_I;
                    C_LW:   state_nxt = S_EX_ADDR;
                    C_SW:   state_nxt = S_EX_ADDR;
                    C_BEQ:  state_nxt = S_BR;
                    C_BNE:  state_nxt = S_BR;
                    C_J:    state_nxt = S_JMP;
                    C_ILL: begin
                        ctl.illegal = 1'b1;
                        state_nxt   = S_IF;
                    end
                endcase
            end
            S_EX_R: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_RT;
                ctl.alu_op    = ALU_FUNCT;
                state_nxt     = S_WB_R;
            end
            S_EX_I: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_op    = ALU_IMM;
                state_nxt     = S_WB_I;
            end
            S_EX_ADDR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_op    = ALU_ADD;
                state_nxt     = (cls == C_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                ctl.mem_read = 1'b1;
                ctl.iord     = 1'b1;
                if (mem_ready_i) begin
                    state_nxt = S_WB_MEM;
                end
            end
            S_MEM_WR: begin
                ctl.mem_write = 1'b1;
                ctl.iord      = 1'b1;
                if (mem_ready_i) begin
                    state_nxt = S_IF;
                end
            end
            S_WB_R: begin
                ctl.reg_write = 1'b1;
                ctl.reg_dst   = 1'b1;
                state_nxt     = S_IF;
            end
            S_WB_I: begin
                ctl.reg_write = 1'b1;
                state_nxt     = S_IF;
            end
            S_WB_MEM: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
                state_nxt      = S_IF;
            end
            S_BR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_RT;
                ctl.alu_op    = ALU_SUB;
                ctl.pc_src    = PC_ALUOUT;
                ctl.pc_write  = (cls == C_BEQ) ? zero_i :
                                (cls == C_BNE) ? !zero_i : 1'b0;
                state_nxt     = S_IF;
            end
            S_JMP: begin
                ctl.pc_write = 1'b1;
                ctl.pc_src   = PC_JUMP;
                state_nxt    = S_IF;
            end
            default: state_nxt = S_IF;
        endcase
    end

    assign pc_write_o   = ctl.pc_write;
    assign pc_src_o     = ctl.pc_src;
    assign ir_write_o   = ctl.ir_write;
    assign iord_o       = ctl.iord;
    assign mem_read_o   = ctl.mem_read;
    assign mem_write_o  = ctl.mem_write;
    assign reg_write_o  = ctl.reg_write;
    assign reg_dst_o    = ctl.reg_dst;
    assign mem_to_reg_o = ctl.mem_to_reg;
    assign alu_src_a_o  = ctl.alu_src_a;
    assign alu_src_b_o  = ctl.alu_src_b;
    assign alu_op_o     = ctl.alu_op;
    assign illegal_o    = ctl.illegal;
    assign state_o      = state;
    assign retired_o    = retired;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: per-instruction cycle plans
// from a class/state table, checked cycle by cycle by a monitor.
module tb_multi_cycle_ctrl;

    localparam int CNT_W = 4;

    localparam int T_IF = 0, T_ID = 1, T_EXR = 2, T_EXI = 3;
    localparam int T_EXA = 4, T_MRD = 5, T_MWR = 6, T_WBR = 7;
    localparam int T_WBI = 8, T_WBM = 9, T_BR = 10, T_JMP = 11;

    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3;
    localparam int K_BEQ = 4, K_BNE = 5, K_J = 6, K_ILL = 7;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic [1:0] pcs;
        logic       irw;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       rgw;
        logic       rdst;
        logic       m2r;
        logic       sa;
        logic [1:0] sb;
        logic [1:0] op;
        logic       ill;
    } ctl_t;

    typedef struct {
        ctl_t             c;
        logic [CNT_W-1:0] ret;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multi_cycle_ctrl_if bus();
    logic             illegal;
    logic [3:0]       state;
    logic [CNT_W-1:0] retired;

    multi_cycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .opcode_i     (bus.opcode),
        .zero_i       (bus.zero),
        .mem_ready_i  (bus.mem_ready),
        .pc_write_o   (bus.pc_write),
        .pc_src_o     (bus.pc_src),
        .ir_write_o   (bus.ir_write),
        .iord_o       (bus.iord),
        .mem_read_o   (bus.mem_read),
        .mem_write_o  (bus.mem_write),
        .reg_write_o  (bus.reg_write),
        .reg_dst_o    (bus.reg_dst),
        .mem_to_reg_o (bus.mem_to_reg),
        .alu_src_a_o  (bus.alu_src_a),
        .alu_src_b_o  (bus.alu_src_b),
        .alu_op_o     (bus.alu_op),
        .illegal_o    (illegal),
        .state_o      (state),
        .retired_o    (retired)
    );

    exp_t             q[$];
    int               checks = 0;
    int               failures = 0;
    logic [CNT_W-1:0] model_ret = '0;
    logic [5:0]       legal_ops[8];

    function automatic bit rbit();
        return bit'($urandom_range(0, 1));
    endfunction

    function automatic int klass(logic [5:0] op);
        case (op)
            6'h00:        return K_R;
            6'h02:        return K_J;
            6'h04:        return K_BEQ;
            6'h05:        return K_BNE;
            6'h08, 6'h0A: return K_I;
            6'h23:        return K_LW;
            6'h2B:        return K_SW;
            default:      return K_ILL;
        endcase
    endfunction

    function automatic ctl_t expect_ctl(int st, bit rdy, bit z, int k);
        ctl_t c;
        c = '0;
        c.st = st[3:0];
        case (st)
            T_IF: begin
                c.mrd = 1'b1;
                c.sb  = 2'b01;
                if (rdy) begin
                    c.irw = 1'b1;
                    c.pcw = 1'b1;
                end
            end
            T_ID: begin
                c.sb  = 2'b11;
                c.ill = (k == K_ILL);
            end
            T_EXR: begin
                c.sa = 1'b1;
                c.op = 2'b10;
            end
            T_EXI: begin
                c.sa = 1'b1;
                c.sb = 2'b10;
                c.op = 2'b11;
            end
            T_EXA: begin
                c.sa = 1'b1;
                c.sb = 2'b10;
            end
            T_MRD: begin
                c.mrd  = 1'b1;
                c.iord = 1'b1;
            end
            T_MWR: begin
                c.mwr  = 1'b1;
                c.iord = 1'b1;
            end
            T_WBR: begin
                c.rgw  = 1'b1;
                c.rdst = 1'b1;
            end
            T_WBI: c.rgw = 1'b1;
            T_WBM: begin
                c.rgw = 1'b1;
                c.m2r = 1'b1;
            end
            T_BR: begin
                c.sa  = 1'b1;
                c.op  = 2'b01;
                c.pcs = 2'b01;
                c.pcw = (k == K_BEQ) ? z : !z;
            end
            T_JMP: begin
                c.pcw = 1'b1;
                c.pcs = 2'b10;
            end
            default: ;
        endcase
        return c;
    endfunction

    function automatic ctl_t actual();
        return {state, bus.pc_write, bus.pc_src, bus.ir_write,
                bus.iord, bus.mem_read, bus.mem_write,
                bus.reg_write, bus.reg_dst, bus.mem_to_reg,
                bus.alu_src_a, bus.alu_src_b, bus.alu_op, illegal};
    endfunction

    // Monitor: one expected record per DUT cycle.
    exp_t mon_e;
    ctl_t mon_a;
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                mon_e = q.pop_front();
                mon_a = actual();
                checks++;
                if (mon_a !== mon_e.c || retired !== mon_e.ret) begin
                    failures++;
                    $display("FAIL cycle t=%0t: got ctl=%h ret=%0d, want ctl=%h ret=%0d",
                             $time, mon_a, retired, mon_e.c, mon_e.ret);
                end
            end
        end
    end

    task automatic cycle(input logic [5:0] op, input int st,
                         input bit rdy, input bit z, input int k);
        exp_t e;
        @(posedge clk);
        #1;
        bus.opcode    = op;
        bus.mem_ready = rdy;
        bus.zero      = z;
        e.c   = expect_ctl(st, rdy, z, k);
        e.ret = model_ret;
        q.push_back(e);
    endtask

    task automatic run_instr(input logic [5:0] op, input int if_w,
                             input int mem_w, input bit zb);
        int k;
        k = klass(op);
        for (int i = 0; i < if_w; i++) cycle(op, T_IF, 1'b0, rbit(), k);
        cycle(op, T_IF, 1'b1, rbit(), k);
        cycle(op, T_ID, rbit(), rbit(), k);
        case (k)
            K_R: begin
                cycle(op, T_EXR, rbit(), rbit(), k);
                cycle(op, T_WBR, rbit(), rbit(), k);
            end
            K_I: begin
                cycle(op, T_EXI, rbit(), rbit(), k);
                cycle(op, T_WBI, rbit(), rbit(), k);
            end
            K_LW: begin
                cycle(op, T_EXA, rbit(), rbit(), k);
                for (int i = 0; i < mem_w; i++)
                    cycle(op, T_MRD, 1'b0, rbit(), k);
                cycle(op, T_MRD, 1'b1, rbit(), k);
                cycle(op, T_WBM, rbit(), rbit(), k);
            end
            K_SW: begin
                cycle(op, T_EXA, rbit(), rbit(), k);
                for (int i = 0; i < mem_w; i++)
                    cycle(op, T_MWR, 1'b0, rbit(), k);
                cycle(op, T_MWR, 1'b1, rbit(), k);
            end
            K_BEQ, K_BNE: cycle(op, T_BR, rbit(), zb, k);
            K_J: cycle(op, T_JMP, rbit(), rbit(), k);
            default: ;
        endcase
        if (k != K_ILL) model_ret++;
    endtask

    task automatic check_reset(input string name);
        ctl_t want;
        want = expect_ctl(T_IF, 1'b0, 1'b0, K_R);
        checks++;
        if (actual() !== want || retired !== '0) begin
            failures++;
            $display("FAIL %s: got ctl=%h ret=%0d, want ctl=%h ret=0",
                     name, actual(), retired, want);
        end
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset_hold");
        bus.mem_ready = 1'b0;
        rst_n = 1'b1;
    endtask

    logic [5:0] rop;

    initial begin
        legal_ops = '{6'h00, 6'h02, 6'h04, 6'h05,
                      6'h08, 6'h0A, 6'h23, 6'h2B};
        bus.opcode    = 6'h00;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        #2;
        check_reset("reset_initial");
        release_reset();

        run_instr(6'h00, 0, 0, 1'b0);
        run_instr(6'h23, 0, 3, 1'b0);
        run_instr(6'h04, 0, 0, 1'b1);
        run_instr(6'h05, 0, 0, 1'b1);
        run_instr(6'h04, 1, 0, 1'b0);
        run_instr(6'h05, 0, 0, 1'b0);
        run_instr(6'h3F, 0, 0, 1'b0);
        run_instr(6'h2B, 2, 0, 1'b0);
        run_instr(6'h02, 0, 0, 1'b0);
        run_instr(6'h08, 0, 0, 1'b0);
        run_instr(6'h0A, 0, 1, 1'b0);

        // Reset in the middle of a stalled store.
        cycle(6'h2B, T_IF, 1'b1, 1'b0, K_SW);
        cycle(6'h2B, T_ID, 1'b0, 1'b0, K_SW);
        cycle(6'h2B, T_EXA, 1'b0, 1'b0, K_SW);
        cycle(6'h2B, T_MWR, 1'b0, 1'b0, K_SW);
        @(negedge clk);
        #1;
        q.delete();
        bus.mem_ready = 1'b1;
        rst_n = 1'b0;
        model_ret = '0;
        #1;
        check_reset("reset_mid_store");
        release_reset();

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0)
                rop = 6'($urandom);
            else
                rop = legal_ops[$urandom_range(0, 7)];
            run_instr(rop, $urandom_range(0, 2),
                      $urandom_range(0, 3), rbit());
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_cycle_ctrl.md
# multi_cycle_ctrl

Moore-style control FSM that sequences a shared-ALU, shared-memory multi-cycle MIPS-subset datapath through fetch, decode, execute, memory and write-back steps. It is the multi-cycle successor to the single-cycle combinational decoder. It drives all datapath mux selects and write enables, and stalls on a memory ready handshake. It also keeps a retired-instruction counter for test and debug.

## Interface
Parameters:
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk_i` input, 1 bit: clock. All state changes happen on the rising edge.
- `rst_i` input, 1 bit: reset, asynchronous and active-low.
- `opcode_i` input, 6 bits: `IR[31:26]`. Stable from ID until the next IF completes.
- `zero_i` input, 1 bit: ALU zero flag. Valid in the same cycle as the BR state.
- `mem_ready_i` input, 1 bit: memory has completed the current access. Sampled only in IF, MEM_RD and MEM_WR.
- `pc_write_o` output, 1 bit: PC load enable.
- `pc_src_o` output, 2 bits: PC source select. 00 = ALU result, 01 = ALUOut (branch target), 10 = jump target.
- `ir_write_o` output, 1 bit: IR load enable. Also loads the MDR.
- `iord_o` output, 1 bit: memory address select. 0 = PC, 1 = ALUOut.
- `mem_read_o` output, 1 bit: memory read request.
- `mem_write_o` output, 1 bit: memory write request.
- `reg_write_o` output, 1 bit: register file write enable.
- `reg_dst_o` output, 1 bit: destination register select. 0 = rt, 1 = rd.
- `mem_to_reg_o` output, 1 bit: write-back data select. 0 = ALUOut, 1 = MDR.
- `alu_src_a_o` output, 1 bit: ALU A select. 0 = PC, 1 = rs data.
- `alu_src_b_o` output, 2 bits: ALU B select. 00 = rt data, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- `alu_op_o` output, 2 bits: ALU operation. 00 = add, 01 = sub, 10 = R-type (use funct), 11 = immediate-by-opcode.
- `illegal_o` output, 1 bit: one-cycle pulse for an unsupported opcode.
- `state_o` output, 4 bits: current state encoding, for debug.
- `retired_o` output, `CNT_W` bits: count of completed instructions.

## Operation
Supported opcodes: R-type 0x00, j 0x02, beq 0x04, bne 0x05, addi 0x08, slti 0x0A, lw 0x23, sw 0x2B.

Any output not listed for a state is 0.

States, with asserted outputs and next state:
- **IF**: `mem_read`=1, `iord`=0, `src_a`=0, `src_b`=01, `alu_op`=00. If `mem_ready_i`=1, also assert `ir_write`=1 and `pc_write`=1 with `pc_src`=00, then go to ID. Otherwise stay in IF.
- **ID**: `src_a`=0, `src_b`=11, `alu_op`=00 (precomputes the branch target). Next state by opcode:
  - R-type → EX_R
  - addi, slti → EX_I
  - lw, sw → EX_ADDR
  - beq, bne → BR
  - j → JMP
  - any other opcode → IF, with `illegal_o`=1
- **EX_R**: `src_a`=1, `src_b`=00, `alu_op`=10 → WB_R.
- **EX_I**: `src_a`=1, `src_b`=10, `alu_op`=11 → WB_I.
- **EX_ADDR**: `src_a`=1, `src_b`=10, `alu_op`=00 → MEM_RD for lw, MEM_WR for sw.
- **MEM_RD**: `mem_read`=1, `iord`=1. Stay until `mem_ready_i`=1, then go to WB_MEM.
- **MEM_WR**: `mem_write`=1, `iord`=1. Stay until `mem_ready_i`=1, then go to IF.
- **WB_R**: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0 → IF.
- **WB_I**: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0 → IF.
- **WB_MEM**: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1 → IF.
- **BR**: `src_a`=1, `src_b`=00, `alu_op`=01, `pc_src`=01. `pc_write` = `zero_i` for beq, `!zero_i` for bne. → IF.
- **JMP**: `pc_write`=1, `pc_src`=10 → IF.

Retired counter:
- `retired_o` increments by 1 on each transition into IF from any state other than ID. The illegal-opcode path does not count.
- Wraps modulo 2^`CNT_W`.

Memory handshake:
- `mem_read_o` and `mem_write_o` are never both 1.
- A request is held constant until `mem_ready_i` is seen.
- `mem_ready_i` is ignored in all other states.

## Timing
- All outputs are combinational decodes of the registered state. The only exceptions are the `mem_ready_i` gating in IF and the `zero_i` gating in BR. `retired_o` is registered.
- Cycle counts with zero wait: R-type, addi, slti and sw take 4; lw takes 5; beq, bne and j take 3; an illegal opcode takes 2.
- Each wait cycle with `mem_ready_i`=0 adds one cycle in IF, MEM_RD or MEM_WR.
- Reset (`rst_i`=0, asynchronous, at any time including mid-access): state = IF and `retired_o` = 0.
  - Output values during reset: `mem_read_o`=1, `iord_o`=0, `alu_src_b_o`=01. All other outputs are 0, including `mem_write_o`, `reg_write_o` and `illegal_o`.
  - An interrupted write-back or store is dropped and does not count.
- Leaving reset: the first IF cycle follows the first rising edge after `rst_i` goes high.

## Structure
- Package `multi_cycle_pkg` holds:
  - the opcode constants
  - the 4-bit state encoding: IF=0, ID=1, EX_R=2, EX_I=3, EX_ADDR=4, MEM_RD=5, MEM_WR=6, WB_R=7, WB_I=8, WB_MEM=9, BR=10, JMP=11
  - the `alu_op`, `pc_src` and `alu_src_b` encodings
- One sub-module, `mc_opcode_decode`: combinational, maps `opcode_i` to an instruction class (R, I-ALU, LW, SW, BEQ, BNE, J, ILLEGAL). Used by the ID next-state logic and by the BR state.

## Test plan
- Reset: drive `rst_i` low while in MEM_WR → `state_o`=0 and `mem_write_o`=0 immediately (asynchronously); `retired_o`=0.
- R-type with `mem_ready_i`=1 → states 0,1,2,7 over 4 cycles. `reg_write_o`=1 and `reg_dst_o`=1 in cycle 4 only. `retired_o` goes 0→1.
- lw with `mem_ready_i` low for 3 cycles in MEM_RD → 8 cycles total. `mem_read_o`=1 and `iord_o`=1 held for all 4 MEM_RD cycles. `mem_to_reg_o`=1 in WB_MEM.
- beq with `zero_i`=1 → in BR, `pc_write_o`=1 and `pc_src_o`=01. bne with `zero_i`=1 → `pc_write_o`=0. Each takes 3 cycles.
- Opcode 0x3F → `illegal_o`=1 for the single ID cycle, then IF; `retired_o` unchanged.
- Sequence sw, j, addi with an IF stall of 2 cycles → `retired_o`=3 after 4+3+4+2 = 13 cycles.
